fexp2_bf16: RTL and testbench

Multi-cycle bfloat16 base-2 exponential unit, y = 2^x; inverse companion of the flog (log2) datapath.
- Converts the float operand to signed Q8.8 fixed point and splits it into integer and fractional parts.
- Computes 2^frac by iterative shift-and-multiply against a constant table.
- Packs integer + BIAS as the result exponent.
- Single operand in flight; valid/ready input handshake; one-cycle result valid pulse.

---
 rtl/fexp2_bf16.sv | 220 ++++++++++++++++++++++
 tb/tb_fexp2_bf16.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fexp2_bf16.sv
// fexp2_bf16: multi-cycle bfloat16 base-2 exponential, y = 2^x.
// The operand is converted to signed Q8.8 and split into integer and fraction.
// 2^frac is built by shift-and-multiply against a table of 2^(2^-i) constants.
// The integer part plus BIAS becomes the result exponent.
// Optional build macro FEXP2_ROUND_EN: round-to-nearest (ties up) at packing.
// Without it the mantissa is truncated. Latency is identical in both builds.
module fexp2_bf16 #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 7,
    parameter int BIAS      = 127,
    parameter int FRAC_BITS = 8,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sign,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [MAN_WIDTH-1:0] fractional,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 s_res_o,
    output logic [EXP_WIDTH-1:0] e_res_o,
    output logic [MAN_WIDTH-1:0] f_res_o,
    output logic                 valid_o
);

    // Signed width used for exponent arithmetic (biased and unbiased).
    localparam int IW      = EXP_WIDTH + 2;
    // Width of the signed Q8.8 operand.
    localparam int XW      = 2 * FRAC_BITS;
    // Fraction bits of the Q2.16 accumulator.
    localparam int AFB     = ACC_WIDTH - 2;
    localparam int CNT_W   = $clog2(FRAC_BITS);
    localparam int COEF_W  = AFB + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_PACK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1) << AFB;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

    // round(2^(2^-i) * 65536) for i = 1..FRAC_BITS, indexed by i-1.
    localparam logic [COEF_W-1:0] C_TAB [FRAC_BITS] = '{
        17'd92682, 17'd77936, 17'd71468, 17'd68438,
        17'd66971, 17'd66250, 17'd65892, 17'd65714
    };

    logic [2:0]             r_state;
    logic                   r_sign;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [MAN_WIDTH-1:0]   r_frac;
    logic signed [IW-1:0]   r_int;
    logic [FRAC_BITS-1:0]   r_xfrac;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_s_res;
    logic [EXP_WIDTH-1:0]   r_e_res;
    logic [MAN_WIDTH-1:0]   r_f_res;
    logic                   r_valid;

    logic signed [IW-1:0]   w_e_unb;
    logic signed [IW-1:0]   w_sh;
    logic [XW-1:0]          w_sig;
    logic [XW-1:0]          w_mag;
    logic [XW-1:0]          w_x;
    logic                   w_special;
    logic [EXP_WIDTH-1:0]   w_sp_e;
    logic [MAN_WIDTH-1:0]   w_sp_f;
    logic [COEF_W-1:0]      w_coef;
    logic                   w_bit;
    logic [ACC_WIDTH-1:0]   w_acc_mul;
    logic [MAN_WIDTH:0]     w_round_sum;
    logic signed [IW-1:0]   w_pack_e_raw;
    logic [EXP_WIDTH-1:0]   w_pack_e;
    logic [MAN_WIDTH-1:0]   w_pack_f;

    assign in_ready = (r_state == S_IDLE);
    assign s_res_o  = r_s_res;
    assign e_res_o  = r_e_res;
    assign f_res_o  = r_f_res;
    assign valid_o  = r_valid;

    // Classify the latched operand and convert it to signed Q8.8.
    always_comb begin
        w_e_unb   = signed'({2'b00, r_exp}) - signed'(IW'(BIAS));
        w_sh      = w_e_unb + signed'(IW'(1));
        w_sig     = XW'({1'b1, r_frac});
        w_mag     = '0;
        w_x       = '0;
        w_special = 1'b1;
        w_sp_e    = '0;
        w_sp_f    = '0;
        if (r_exp == EXP_MAX) begin
            if (r_frac != '0) begin
                // NaN in, canonical quiet NaN out.
                w_sp_e = EXP_MAX;
                w_sp_f = MAN_WIDTH'(1) << (MAN_WIDTH - 1);
            end else if (!r_sign) begin
                w_sp_e = EXP_MAX;
            end
        end else if (r_exp == '0) begin
            // Zero and denormals: 2^0 = 1.0.
            w_sp_e = EXP_WIDTH'(BIAS);
        end else if (w_e_unb < -signed'(IW'(FRAC_BITS))) begin
            // Below one Q8.8 LSB: also 1.0.
            w_sp_e = EXP_WIDTH'(BIAS);
        end else if (w_e_unb >= signed'(IW'(MAN_WIDTH))) begin
            // |x| >= 128 saturates to +inf or flushes to zero.
            if (!r_sign) begin
                w_sp_e = EXP_MAX;
            end
        end else begin
            w_special = 1'b0;
            if (w_sh >= 0) begin
                w_mag = w_sig << 4'(w_sh);
            end else begin
                w_mag = w_sig >> 4'(signed'(IW'(0)) - w_sh);
            end
            w_x = r_sign ? (XW'(0) - w_mag) : w_mag;
        end
    end

    // One shift-and-multiply step of the 2^frac evaluation.
    always_comb begin
        w_coef    = C_TAB[r_cnt];
        w_bit     = r_xfrac[CNT_W'(FRAC_BITS - 1) - r_cnt];
        w_acc_mul = ACC_WIDTH'(({{COEF_W{1'b0}}, r_acc} * {{ACC_WIDTH{1'b0}}, w_coef}) >> AFB);
    end

    // Pack integer part and accumulator mantissa, with optional rounding.
    always_comb begin
`ifdef FEXP2_ROUND_EN
        w_round_sum = {1'b0, r_acc[AFB-1 -: MAN_WIDTH]} + (MAN_WIDTH+1)'(r_acc[AFB-1-MAN_WIDTH]);
`else
        w_round_sum = {1'b0, r_acc[AFB-1 -: MAN_WIDTH]};
`endif
        w_pack_e_raw = r_int + signed'(IW'(BIAS)) + signed'(IW'(w_round_sum[MAN_WIDTH]));
        w_pack_e     = w_pack_e_raw[EXP_WIDTH-1:0];
        w_pack_f     = w_round_sum[MAN_WIDTH] ? '0 : w_round_sum[MAN_WIDTH-1:0];
        if (w_pack_e_raw <= 0) begin
            // No denormals: flush to zero.
            w_pack_e = '0;
            w_pack_f = '0;
        end else if (w_pack_e_raw >= signed'(IW'(EXP_MAX))) begin
            w_pack_e = EXP_MAX;
            w_pack_f = '0;
        end
    end

    // Control FSM, operand capture, iteration and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_int   <= '0;
            r_xfrac <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_s_res <= 1'b0;
            r_e_res <= '0;
            r_f_res <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= sign;
                        r_exp   <= exponent;
                        r_frac  <= fractional;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_special) begin
                        r_s_res <= 1'b0;
                        r_e_res <= w_sp_e;
                        r_f_res <= w_sp_f;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_int   <= IW'(signed'(w_x[XW-1:FRAC_BITS]));
                        r_xfrac <= w_x[FRAC_BITS-1:0];
                        r_acc   <= ACC_ONE;
                        r_cnt   <= '0;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (w_bit) begin
                        r_acc <= w_acc_mul;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(FRAC_BITS - 1)) begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    r_s_res <= 1'b0;
                    r_e_res <= w_pack_e;
                    r_f_res <= w_pack_f;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fexp2_bf16.sv
// Testbench for fexp2_bf16: directed operands, handshake/abort scenarios and
// random operands checked against a behavioural 2^x model.
module tb_fexp2_bf16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sign;
    logic [7:0] exponent;
    logic [6:0] fractional;
    logic       in_valid;
    logic       in_ready;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    int total = 0;
    int bad   = 0;
    longint coef [1:8];

    fexp2_bf16 dut (
        .clk        (clk),
        .rst        (rst),
        .sign       (sign),
        .exponent   (exponent),
        .fractional (fractional),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s_res_o    (s_res_o),
        .e_res_o    (e_res_o),
        .f_res_o    (f_res_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: bf16 -> truncated Q8.8 -> floor/fraction split -> product of
    // table factors -> pack with limits.
    function automatic void ref_exp2(input logic [15:0] op, output logic [15:0] res, output int lat);
        int     s;
        int     ex;
        int     fr;
        int     e_unb;
        int     sh;
        int     e;
        longint mag;
        longint x;
        longint fr8;
        longint ip;
        longint acc;
        longint mant;
        s     = {31'd0, op[15]};
        ex    = {24'd0, op[14:7]};
        fr    = {25'd0, op[6:0]};
        e_unb = ex - 127;
        lat   = 2;
        if (ex == 255) begin
            res = (fr != 0) ? 16'h7FC0 : (s != 0 ? 16'h0000 : 16'h7F80);
        end else if (ex == 0 || e_unb < -8) begin
            res = 16'h3F80;
        end else if (e_unb >= 7) begin
            res = (s != 0) ? 16'h0000 : 16'h7F80;
        end else begin
            lat = 11;
            sh  = e_unb + 1;
            mag = (sh >= 0) ? (longint'(128 + fr) << sh) : (longint'(128 + fr) >> (-sh));
            x   = (s != 0) ? -mag : mag;
            fr8 = ((x % 256) + 256) % 256;
            ip  = (x - fr8) / 256;
            acc = 65536;
            for (int i = 1; i <= 8; i++) begin
                if (((fr8 >> (8 - i)) & 1) != 0) begin
                    acc = (acc * coef[i]) >> 16;
                end
            end
            e    = int'(ip) + 127;
            mant = (acc >> 9) & 127;
`ifdef FEXP2_ROUND_EN
            mant = mant + ((acc >> 8) & 1);
            if (mant == 128) begin
                mant = 0;
                e    = e + 1;
            end
`endif
            if (e <= 0) begin
                res = 16'h0000;
            end else if (e >= 255) begin
                res = 16'h7F80;
            end else begin
                res = {1'b0, 8'(e), 7'(mant)};
            end
        end
    endfunction

    // Issue one operand, then check latency, busy window, result and hold.
    task automatic run_op(input logic [15:0] op, input logic [15:0] exp_res, input int exp_lat, input string tag);
        int lat;
        int low_cnt;
        @(negedge clk);
        check({tag, "/ready_idle"}, 32'(in_ready), 32'd1);
        {sign, exponent, fractional} = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat     = 0;
        low_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!in_ready) low_cnt++;
            if (valid_o) begin
                lat = c;
                break;
            end
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/busy_cycles"}, 32'(low_cnt), 32'(exp_lat));
        check({tag, "/result"}, 32'({s_res_o, e_res_o, f_res_o}), 32'(exp_res));
        @(negedge clk);
        check({tag, "/pulse_end"}, 32'(valid_o), 32'd0);
        check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "/hold"}, 32'({s_res_o, e_res_o, f_res_o}), 32'(exp_res));
    endtask

    logic [15:0] d_op  [11] = '{16'h3F80, 16'h3F00, 16'hBF80, 16'hBF00, 16'h4300, 16'hC348,
                                16'h7FC1, 16'h0000, 16'hFF80, 16'hC2FE, 16'hC2FC};
    logic [15:0] d_res [11] = '{16'h4000, 16'h3FB5, 16'h3F00, 16'h3F35, 16'h7F80, 16'h0000,
                                16'h7FC0, 16'h3F80, 16'h0000, 16'h0000, 16'h0080};
    int          d_lat [11] = '{11, 11, 11, 11, 2, 2, 2, 2, 2, 11, 11};

    initial begin
        logic [15:0] rop;
        logic [15:0] rres;
        int          rlat;
        int          pulses;
        int          lat;

        for (int i = 1; i <= 8; i++) begin
            coef[i] = longint'($rtoi((2.0 ** (1.0 / (2.0 ** i))) * 65536.0 + 0.5));
        end

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; sign = 1'b0; exponent = '0; fractional = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/valid_o", 32'(valid_o), 32'd0);
        check("reset/result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
        rst = 1'b0;

        // Directed operands from the test plan.
        for (int k = 0; k < 11; k++) begin
            run_op(d_op[k], d_res[k], d_lat[k], $sformatf("dir_%04h", d_op[k]));
        end

        // in_valid held high while busy with a different operand.
        @(negedge clk);
        {sign, exponent, fractional} = 16'h3F00;
        in_valid = 1'b1;
        @(posedge clk);
        #1 {sign, exponent, fractional} = 16'hBF80;
        pulses = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
            if (c == 11) begin
                check("busy/valid_c11", 32'(valid_o), 32'd1);
                check("busy/result", 32'({s_res_o, e_res_o, f_res_o}), 32'h3FB5);
            end
        end
        check("busy/pulses", 32'(pulses), 32'd1);
        @(negedge clk);
        check("busy/ready_back", 32'(in_ready), 32'd1);
        check("busy/no_extra", 32'(valid_o), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = c;
                break;
            end
        end
        check("busy/next_latency", 32'(lat), 32'd11);
        check("busy/next_result", 32'({s_res_o, e_res_o, f_res_o}), 32'h3F00);

        // Reset mid-iteration aborts the operand.
        @(negedge clk);
        {sign, exponent, fractional} = 16'h3F80;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort/in_ready", 32'(in_ready), 32'd1);
        check("abort/valid_o", 32'(valid_o), 32'd0);
        check("abort/result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        check("abort/no_valid", 32'(pulses), 32'd0);

        // Random operands, mostly in the converted range.
        for (int n = 0; n < 40; n++) begin
            rop[15]  = 1'($urandom_range(0, 1));
            rop[14:7] = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(119, 134)) : 8'($urandom_range(0, 255));
            rop[6:0] = 7'($urandom_range(0, 127));
            ref_exp2(rop, rres, rlat);
            run_op(rop, rres, rlat, $sformatf("rnd%0d_%04h", n, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
